// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - operation codes and shared constants for the add/subtract accumulator
package sumador_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_ACC_ADD = 3'b010,
        OP_ACC_SUB = 3'b011,
        OP_LOAD    = 3'b100,
        OP_CLR     = 3'b101,
        OP_RSV0    = 3'b110,
        OP_RSV1    = 3'b111
    } op_t;

endpackage

// File: rtl/nucleo_suma_resta.sv
// rtl/nucleo_suma_resta.sv - combinational add/subtract core with raw carry and signed overflow
//   x, y : operands        sub  : 1 = x - y, 0 = x + y
//   r    : WIDTH-bit sum   cout : raw carry out (subtract: 1 = no borrow)
//   ovf  : signed overflow of the raw operation
module nucleo_suma_resta #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   sum;

    // Subtraction is x + ~y + 1, so the carry-in doubles as the subtract select.
    assign y_eff = sub ? ~y : y;
    assign sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    assign r     = sum[WIDTH-1:0];
    assign cout  = sum[WIDTH];

    // Using the effective (possibly inverted) y folds both overflow rules into one:
    // operands of equal sign producing a result of the other sign.
    assign ovf = (x[WIDTH-1] == y_eff[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/sumador_restador_acumulador.sv
// rtl/sumador_restador_acumulador.sv - registered add/subtract unit with accumulator, flags and handshake
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operation handshake (op, a, b)
//   out_valid/out_ready: result handshake (c, cout, ovf, zero, neg, err)
//   acc                : accumulator value
//   op_count           : accepted operations, wraps
import sumador_pkg::*;

module sumador_restador_acumulador #(
    parameter int WIDTH = 4,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    op_t              op_e;
    logic             accept;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] core_r;
    logic             core_cout;
    logic             core_ovf;
    logic [WIDTH-1:0] c_next;
    logic             cout_next;
    logic             ovf_next;
    logic             err_next;
    logic [WIDTH-1:0] acc_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_e     = op_t'(op);

    nucleo_suma_resta #(
        .WIDTH (WIDTH)
    ) u_nucleo (
        .x    (x),
        .y    (y),
        .sub  (sub),
        .r    (core_r),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    always_comb begin
        x         = a;
        y         = b;
        sub       = 1'b0;
        arith     = 1'b0;
        c_next    = '0;
        cout_next = 1'b0;
        ovf_next  = 1'b0;
        err_next  = 1'b0;
        acc_next  = acc;

        case (op_e)
            OP_ADD: begin
                arith = 1'b1;
            end
            OP_SUB: begin
                arith = 1'b1;
                sub   = 1'b1;
            end
            OP_ACC_ADD: begin
                x     = acc;
                y     = a;
                arith = 1'b1;
            end
            OP_ACC_SUB: begin
                x     = acc;
                y     = a;
                arith = 1'b1;
                sub   = 1'b1;
            end
            OP_LOAD: begin
                c_next   = a;
                acc_next = a;
            end
            OP_CLR: begin
                c_next   = '0;
                acc_next = '0;
            end
            default: begin
                err_next = 1'b1;
            end
        endcase

        if (arith) begin
            cout_next = core_cout;
            ovf_next  = core_ovf;
            // Saturate toward the sign of x: only x's sign can be "kept" on overflow.
            if ((SAT != 0) && core_ovf) begin
                c_next = x[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end else begin
                c_next = core_r;
            end
        end

        // Accumulate ops write back the final (possibly saturated) result.
        if ((op_e == OP_ACC_ADD) || (op_e == OP_ACC_SUB)) begin
            acc_next = c_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                c         <= c_next;
                cout      <= cout_next;
                ovf       <= ovf_next;
                zero      <= (c_next == '0);
                neg       <= c_next[WIDTH-1];
                err       <= err_next;
                acc       <= acc_next;
                op_count  <= op_count + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sumador_restador_acumulador.sv
// tb/tb_sumador_restador_acumulador.sv - directed self-checking bench for both wrap and saturating builds
`timescale 1ns/1ps
module tb_sumador_restador_acumulador;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;

    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    logic [3:0] c,         c_s;
    logic       cout,      cout_s;
    logic       ovf,       ovf_s;
    logic       zero,      zero_s;
    logic       neg,       neg_s;
    logic       err,       err_s;
    logic [3:0] acc,       acc_s;
    logic [7:0] op_count,  op_count_s;

    int checks;
    int errors;

    sumador_restador_acumulador #(.WIDTH(4), .SAT(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .err(err),
        .acc(acc), .op_count(op_count)
    );

    sumador_restador_acumulador #(.WIDTH(4), .SAT(1), .CNT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .c(c_s), .cout(cout_s), .ovf(ovf_s), .zero(zero_s), .neg(neg_s), .err(err_s),
        .acc(acc_s), .op_count(op_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operation, let it be accepted on the next edge, sample 1ns later.
    task automatic apply(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv);
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'b000;
        a         = 4'h0;
        b         = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_acc", acc, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // ADD 3+4
        apply(3'b000, 4'd3, 4'd4);
        chk("add_valid", out_valid, 1);
        chk("add_c", c, 4'h7);
        chk("add_cout", cout, 0);
        chk("add_ovf", ovf, 0);
        chk("add_zero", zero, 0);
        chk("add_neg", neg, 0);
        chk("add_err", err, 0);

        // Idle cycle with out_ready: result drains
        @(posedge clk);
        #1;
        chk("drain_valid", out_valid, 0);

        // Subtraction cases
        apply(3'b001, 4'd3, 4'd5);
        chk("sub35_c", c, 4'hE);
        chk("sub35_cout", cout, 0);
        chk("sub35_neg", neg, 1);
        chk("sub35_ovf", ovf, 0);
        apply(3'b001, 4'd5, 4'd3);
        chk("sub53_c", c, 4'h2);
        chk("sub53_cout", cout, 1);
        apply(3'b001, 4'd4, 4'd4);
        chk("sub44_c", c, 4'h0);
        chk("sub44_zero", zero, 1);
        chk("sub44_cout", cout, 1);

        // Overflow: wrap vs saturate
        apply(3'b000, 4'd7, 4'd1);
        chk("ovf_add_c", c, 4'h8);
        chk("ovf_add_ovf", ovf, 1);
        chk("ovf_add_neg", neg, 1);
        chk("ovf_add_c_sat", c_s, 4'h7);
        chk("ovf_add_ovf_sat", ovf_s, 1);
        chk("ovf_add_neg_sat", neg_s, 0);
        apply(3'b001, 4'h8, 4'h1);
        chk("ovf_sub_c", c, 4'h7);
        chk("ovf_sub_c_sat", c_s, 4'h8);
        chk("ovf_sub_ovf_sat", ovf_s, 1);
        chk("ovf_sub_cout_sat", cout_s, 1);

        // Back-to-back accumulator chain from a fresh reset
        pulse_reset();
        apply(3'b100, 4'd5, 4'd0);
        chk("load_c", c, 4'h5);
        chk("load_acc", acc, 4'h5);
        apply(3'b010, 4'd3, 4'd0);
        chk("accadd_c", c, 4'h8);
        chk("accadd_acc_sat", acc_s, 4'h7);
        apply(3'b011, 4'd10, 4'd0);
        chk("accsub_c", c, 4'hE);
        chk("accsub_cout", cout, 0);
        chk("accsub_acc", acc, 4'hE);
        chk("accsub_count", op_count, 8'd3);
        chk("accsub_c_sat", c_s, 4'h7);
        chk("accsub_ovf_sat", ovf_s, 1);
        chk("accsub_acc_sat", acc_s, 4'h7);

        // CLR
        apply(3'b101, 4'd9, 4'd9);
        chk("clr_c", c, 4'h0);
        chk("clr_zero", zero, 1);
        chk("clr_acc", acc, 4'h0);
        chk("clr_count", op_count, 8'd4);

        // Backpressure
        apply(3'b000, 4'd1, 4'd2);
        chk("bp_first_c", c, 4'h3);
        out_ready = 1'b0;
        op        = 3'b000;
        a         = 4'd2;
        b         = 4'd2;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_c", c, 4'h3);
            chk("bp_count", op_count, 8'd5);
            chk("bp_acc", acc, 4'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_queued_c", c, 4'h4);
        chk("bp_queued_count", op_count, 8'd6);

        // Asynchronous reset with a pending result
        apply(3'b100, 4'd6, 4'd0);
        chk("pre_rst_acc", acc, 4'h6);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_acc", acc, 0);
        chk("arst_count", op_count, 0);
        chk("arst_c", c, 0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Reserved op
        apply(3'b110, 4'd5, 4'd3);
        chk("rsv_err", err, 1);
        chk("rsv_c", c, 4'h0);
        chk("rsv_cout", cout, 0);
        chk("rsv_ovf", ovf, 0);
        chk("rsv_acc", acc, 4'h0);
        chk("rsv_count", op_count, 8'd1);
        apply(3'b000, 4'd1, 4'd1);
        chk("post_rsv_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
